ped_button_request: RTL and testbench
=====================================

# ped_button_request

Pedestrian push-button front end for the traffic light system. Synchronises and debounces a raw mechanical button, emits a one-cycle press pulse, and holds a latched crossing request until the traffic state machine acknowledges it. Sits directly upstream of the traffic Moore controller, which samples `req` and pulses `ack` when the pedestrian phase begins. Also supplies a saturating press count for the seven-segment display path.

## Interface
- `DB_CYCLES`, default 20'd1_000_000 — stable-input cycles needed to accept a level change (≥2).
- `CNT_W`, default 20 — debounce counter width; must hold `DB_CYCLES-1`.
- `clk`  in  1  system clock (undivided board clock).
- `rst`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  raw button, active-high, asynchronous to `clk`, may bounce.
- `ack`  in  1  one-cycle pulse from the traffic controller: request serviced.
- `btn_level`  out  1  debounced button level.
- `press_pulse`  out  1  one-cycle pulse on each accepted press (rising debounced edge).
- `req`  out  1  latched pedestrian request.
- `press_cnt`  out  4  presses accepted since last service, saturating at 15.

## Operation
- Synchroniser: two flops, `btn_raw` → `s1` → `btn_s`; reset to 0. Only `btn_s` feeds the FSM.
- Debounce FSM, 4 states, reset state IDLE_LOW, counter reset 0:
  - IDLE_LOW: `btn_s`=1 → WAIT_HIGH, cnt←0.
  - WAIT_HIGH: `btn_s`=0 → IDLE_LOW (bounce rejected); else cnt=`DB_CYCLES-1` → IDLE_HIGH, `btn_level`←1, `press_pulse`←1; else cnt←cnt+1.
  - IDLE_HIGH: `btn_s`=0 → WAIT_LOW, cnt←0.
  - WAIT_LOW: `btn_s`=1 → IDLE_HIGH; else cnt=`DB_CYCLES-1` → IDLE_LOW, `btn_level`←0 (no pulse); else cnt←cnt+1.
- `press_pulse` is registered, high exactly one cycle per IDLE_HIGH entry from WAIT_HIGH.
- Request latch, evaluated each cycle:
  - `press_pulse`=1 and `ack`=1: `req`←1, `press_cnt`←1 (set wins; press counts as new request).
  - `press_pulse`=1 only: `req`←1, `press_cnt`←min(`press_cnt`+1, 15).
  - `ack`=1 only: `req`←0, `press_cnt`←0.
  - `ack` while `req`=0: no effect.
- Counter never exceeds `DB_CYCLES-1`; no wrap.

## Timing
- Reset values: `btn_level`=0, `press_pulse`=0, `req`=0, `press_cnt`=0, FSM IDLE_LOW, sync flops 0. Reset asserted mid-debounce aborts immediately; after release a held button is re-debounced from scratch and yields one new pulse.
- Press latency: if `btn_raw` is first sampled high at edge E0 and stays high, `btn_level`, `press_pulse` and `req` go high after edge E0+`DB_CYCLES`+2; `press_cnt` updates at the same edge.
- Release latency: `btn_level` falls after edge E0'+`DB_CYCLES`+2 from the first low sample.
- Any opposite `btn_s` value during WAIT_* restarts qualification; glitches shorter than `DB_CYCLES` cycles at `btn_s` produce no output change.
- `ack` takes effect at the next edge: `req` low the cycle after `ack`.
- Held button produces a single pulse regardless of hold time.

## Test plan
- Reset: hold `rst`=0 with `btn_raw` toggling → all outputs 0; release with `btn_raw`=0 → outputs stay 0.
- Clean press, `DB_CYCLES`=4: `btn_raw` high before edge 0, held 20 cycles → `btn_level`/`press_pulse`/`req` high after edge 6, `press_pulse` low after edge 7, `press_cnt`=1; release → `btn_level` low 6 edges after first low sample.
- Bounce: `btn_raw` pattern 1,1,0,1,0 then steady 1 (`DB_CYCLES`=4) → exactly one `press_pulse`, timed from start of steady high; 3-cycle glitch alone → no pulse.
- Count/saturation: 17 clean presses without `ack` → `press_cnt` 1..15 then holds 15, `req` stays 1; `ack` → `req`=0, `press_cnt`=0 next cycle.
- Simultaneous: `ack` on same cycle as `press_pulse` with `press_cnt`=5 → `req`=1, `press_cnt`=1; `ack` with `req`=0 → no change.
- Reset mid-operation: assert `rst` during WAIT_HIGH and while `req`=1 with button held → outputs 0 immediately; after release, one pulse `DB_CYCLES`+2 edges later, `req`=1, `press_cnt`=1.

Source files
------------

// File: rtl/ped_button_request_if.sv
// Pedestrian button request bundle: raw button and ack in, debounced level,
// press pulse, latched request and press count out.
interface ped_button_request_if;
  logic       btn_raw;
  logic       ack;
  logic       btn_level;
  logic       press_pulse;
  logic       req;
  logic [3:0] press_cnt;

  modport master (
    output btn_raw,
    output ack,
    input  btn_level,
    input  press_pulse,
    input  req,
    input  press_cnt
  );

  modport slave (
    input  btn_raw,
    input  ack,
    output btn_level,
    output press_pulse,
    output req,
    output press_cnt
  );
endinterface

// File: rtl/ped_button_request.sv
// Pedestrian push-button front end: two-flop synchroniser, 4-state debounce
// FSM with one-cycle press pulse, and an ack-cleared request latch with count.
module ped_button_request #(
  parameter int              CNT_W     = 20,
  parameter logic [CNT_W-1:0] DB_CYCLES = 20'd1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  ped_button_request_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = DB_CYCLES - CNT_ONE;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  logic             s1_q;
  logic             btn_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             req_q, req_d;
  logic [3:0]       pcnt_q, pcnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      req_q   <= 1'b0;
      pcnt_q  <= 4'd0;
    end else begin
      s1_q    <= bus.btn_raw;
      btn_s_q <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      req_q   <= req_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (btn_s_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!btn_s_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  // The latch keys off the accept event itself so req and press_cnt move on
  // the same edge as the registered press pulse rises.
  always_comb begin
    req_d  = req_q;
    pcnt_d = pcnt_q;
    if (pulse_d && bus.ack) begin
      req_d  = 1'b1;
      pcnt_d = 4'd1;
    end else if (pulse_d) begin
      req_d = 1'b1;
      if (pcnt_q != 4'd15) pcnt_d = pcnt_q + 4'd1;
    end else if (bus.ack && req_q) begin
      req_d  = 1'b0;
      pcnt_d = 4'd0;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.press_pulse = pulse_q;
  assign bus.req         = req_q;
  assign bus.press_cnt   = pcnt_q;

endmodule

// File: tb/tb_ped_button_request.sv
// Directed bench for ped_button_request with DB_CYCLES=4 (accept 7 ticks after
// the input change is driven, i.e. edge E0+6).
module tb_ped_button_request;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  ped_button_request_if bus ();

  ped_button_request #(
    .CNT_W     (20),
    .DB_CYCLES (20'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    bus.btn_raw = 1'b1;
    tick(8);
    bus.btn_raw = 1'b0;
    tick(8);
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw = i[0];
      tick(1);
      vectors++;
      if ({bus.btn_level, bus.press_pulse, bus.req, bus.press_cnt} !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold: outputs=%b expected 0", {bus.btn_level, bus.press_pulse, bus.req, bus.press_cnt});
      end
    end
    bus.btn_raw = 1'b0;
    rst = 1'b1;
    tick(10);
    vectors++;
    if ({bus.btn_level, bus.press_pulse, bus.req, bus.press_cnt} !== 7'd0) begin
      errors++;
      $display("FAIL reset_release: outputs=%b expected 0", {bus.btn_level, bus.press_pulse, bus.req, bus.press_cnt});
    end
  endtask

  task automatic test_clean_press();
    int extra;
    bus.btn_raw = 1'b1;
    tick(6);
    vectors++;
    if (bus.btn_level !== 1'b0 || bus.press_pulse !== 1'b0 || bus.req !== 1'b0) begin
      errors++;
      $display("FAIL press_early: level=%b pulse=%b req=%b expected 0 0 0", bus.btn_level, bus.press_pulse, bus.req);
    end
    tick(1);
    vectors++;
    if (bus.btn_level !== 1'b1 || bus.press_pulse !== 1'b1 || bus.req !== 1'b1 || bus.press_cnt !== 4'd1) begin
      errors++;
      $display("FAIL press_accept: level=%b pulse=%b req=%b cnt=%0d expected 1 1 1 1", bus.btn_level, bus.press_pulse, bus.req, bus.press_cnt);
    end
    tick(1);
    vectors++;
    if (bus.press_pulse !== 1'b0 || bus.btn_level !== 1'b1) begin
      errors++;
      $display("FAIL press_pulse_width: pulse=%b level=%b expected 0 1", bus.press_pulse, bus.btn_level);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.press_pulse) extra++;
    end
    vectors++;
    if (extra != 0 || bus.press_cnt !== 4'd1) begin
      errors++;
      $display("FAIL press_hold: extra_pulses=%0d cnt=%0d expected 0 1", extra, bus.press_cnt);
    end
    bus.btn_raw = 1'b0;
    tick(6);
    vectors++;
    if (bus.btn_level !== 1'b1) begin
      errors++;
      $display("FAIL release_early: level=%b expected 1", bus.btn_level);
    end
    tick(1);
    vectors++;
    if (bus.btn_level !== 1'b0 || bus.press_pulse !== 1'b0 || bus.req !== 1'b1) begin
      errors++;
      $display("FAIL release: level=%b pulse=%b req=%b expected 0 0 1", bus.btn_level, bus.press_pulse, bus.req);
    end
    do_ack();
    vectors++;
    if (bus.req !== 1'b0 || bus.press_cnt !== 4'd0) begin
      errors++;
      $display("FAIL ack_clear: req=%b cnt=%0d expected 0 0", bus.req, bus.press_cnt);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pattern;
    int pulses;
    int first;
    pattern = 5'b01011;
    pulses  = 0;
    first   = -1;
    for (int i = 0; i < 5; i++) begin
      bus.btn_raw = pattern[i];
      tick(1);
      if (bus.press_pulse) pulses++;
    end
    bus.btn_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.press_pulse) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (pulses != 1 || first != 6) begin
      errors++;
      $display("FAIL bounce_pulse: pulses=%0d at_tick=%0d expected 1 at 6", pulses, first);
    end
    bus.btn_raw = 1'b0;
    tick(8);
    do_ack();
    pulses = 0;
    bus.btn_raw = 1'b1;
    tick(3);
    bus.btn_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.press_pulse || bus.btn_level) pulses++;
      tick(1);
    end
    vectors++;
    if (pulses != 0 || bus.req !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: active_cycles=%0d req=%b expected 0 0", pulses, bus.req);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    for (int i = 1; i <= 17; i++) begin
      press();
      exp_cnt = (i > 15) ? 4'd15 : 4'(i);
      vectors++;
      if (bus.press_cnt !== exp_cnt || bus.req !== 1'b1) begin
        errors++;
        $display("FAIL sat_press%0d: cnt=%0d req=%b expected %0d 1", i, bus.press_cnt, bus.req, exp_cnt);
      end
    end
    do_ack();
    vectors++;
    if (bus.req !== 1'b0 || bus.press_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_ack: req=%b cnt=%0d expected 0 0", bus.req, bus.press_cnt);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) press();
    vectors++;
    if (bus.press_cnt !== 4'd5) begin
      errors++;
      $display("FAIL simul_pre: cnt=%0d expected 5", bus.press_cnt);
    end
    bus.btn_raw = 1'b1;
    tick(6);
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    vectors++;
    if (bus.press_pulse !== 1'b1 || bus.req !== 1'b1 || bus.press_cnt !== 4'd1) begin
      errors++;
      $display("FAIL simul_ack_press: pulse=%b req=%b cnt=%0d expected 1 1 1", bus.press_pulse, bus.req, bus.press_cnt);
    end
    bus.btn_raw = 1'b0;
    tick(8);
    do_ack();
    do_ack();
    tick(1);
    vectors++;
    if (bus.req !== 1'b0 || bus.press_cnt !== 4'd0 || bus.press_pulse !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: req=%b cnt=%0d pulse=%b expected 0 0 0", bus.req, bus.press_cnt, bus.press_pulse);
    end
  endtask

  task automatic reset_and_expect(input string tag);
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.btn_level, bus.press_pulse, bus.req, bus.press_cnt} !== 7'd0) begin
      errors++;
      $display("FAIL %s_async: outputs=%b expected 0", tag, {bus.btn_level, bus.press_pulse, bus.req, bus.press_cnt});
    end
    tick(3);
    rst = 1'b1;
    tick(6);
    vectors++;
    if (bus.btn_level !== 1'b0 || bus.press_pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: level=%b pulse=%b expected 0 0", tag, bus.btn_level, bus.press_pulse);
    end
    tick(1);
    vectors++;
    if (bus.press_pulse !== 1'b1 || bus.req !== 1'b1 || bus.press_cnt !== 4'd1) begin
      errors++;
      $display("FAIL %s_repress: pulse=%b req=%b cnt=%0d expected 1 1 1", tag, bus.press_pulse, bus.req, bus.press_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.btn_raw = 1'b1;
    tick(4);
    reset_and_expect("rst_wait");
    tick(5);
    reset_and_expect("rst_req");
    bus.btn_raw = 1'b0;
    tick(8);
    do_ack();
  endtask

  initial begin
    vectors     = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.btn_raw = 1'b0;
    bus.ack     = 1'b0;
    #2;
    test_reset();
    test_clean_press();
    test_bounce();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
